// File: rtl/mpi_pkt_pkg.sv
// Eager-message packet layout shared by the send packetizer and receive CAM.
// Field offsets, message type codes, request entry type and packet builder.
package mpi_pkt_pkg;

  localparam int PKT_W          = 128;
  localparam int PKT_TYPE_HI    = 127;
  localparam int PKT_TYPE_LO    = 120;
  localparam int PKT_RSVD_HI    = 119;
  localparam int PKT_RSVD_LO    = 112;
  localparam int PKT_DST_HI     = 111;
  localparam int PKT_DST_LO     = 104;
  localparam int PKT_PATTERN_HI = 103;
  localparam int PKT_PATTERN_LO = 88;
  localparam int PKT_PAYLOAD_HI = 87;
  localparam int PKT_PAYLOAD_LO = 56;
  localparam int PKT_SEQ_HI     = 55;
  localparam int PKT_SEQ_LO     = 40;

  localparam logic [7:0] MSG_EAGER = 8'h01;

  typedef struct packed {
    logic [7:0]  dst;
    logic [7:0]  src;
    logic [7:0]  tag;
    logic [31:0] payload;
  } req_entry_t;

  localparam int REQ_ENTRY_W = $bits(req_entry_t);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } send_state_e;

  // Match pattern {src, tag} lands in [103:88] for the receive CAM.
  function automatic logic [PKT_W-1:0] build_pkt(
    input req_entry_t e,
    input logic [15:0] seq
  );
    logic [PKT_W-1:0] p;
    p = '0;
    p[PKT_TYPE_HI:PKT_TYPE_LO]       = MSG_EAGER;
    p[PKT_DST_HI:PKT_DST_LO]         = e.dst;
    p[PKT_PATTERN_HI:PKT_PATTERN_LO] = {e.src, e.tag};
    p[PKT_PAYLOAD_HI:PKT_PAYLOAD_LO] = e.payload;
    p[PKT_SEQ_HI:PKT_SEQ_LO]         = seq;
    return p;
  endfunction

endpackage

// File: rtl/send_fifo.sv
// Synchronous request FIFO with registered occupancy count, async reset.
// Ports: push_i/wdata_i write, pop_i/rdata_o read head, full_o, empty_o.
module send_fifo #(
  parameter int DW = 56,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == DEPTH);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers are AW bits wide, so they wrap modulo depth by themselves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mpi_send_packetizer.sv
// MPI eager-send packetizer: buffers send requests, emits 128-bit packets.
// Ports: req_* request side, tx_* network side, Q_empty, sent_count.
// Optional MPI_SEND_SEQ_EN: adds 16-bit sequence stamp in [55:40].
module mpi_send_packetizer
  import mpi_pkt_pkg::*;
#(
  parameter int packetizer_width = 128,
  parameter int RANK_BIT         = 8,
  parameter int TAG_BIT          = 8,
  parameter int FIFO_ADDR_WIDTH  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [RANK_BIT-1:0]         my_rank,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [RANK_BIT-1:0]         req_dst_rank,
  input  logic [TAG_BIT-1:0]          req_tag,
  input  logic [31:0]                 req_payload,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [packetizer_width-1:0] tx_message,
  output logic                        Q_empty,
  output logic [31:0]                 sent_count
);

  send_state_e                 state_q;
  logic                        tx_valid_q;
  logic [packetizer_width-1:0] tx_msg_q;
  logic [31:0]                 sent_q;

  req_entry_t wr_entry;
  req_entry_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic [15:0] seq_cur;

  always_comb begin
    wr_entry         = '0;
    wr_entry.dst     = req_dst_rank;
    wr_entry.src     = my_rank;
    wr_entry.tag     = req_tag;
    wr_entry.payload = req_payload;
  end

  // Ready is purely "not full": a same-cycle pop never frees room.
  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;

  // IDLE loads whenever data exists; SEND reloads only on acceptance.
  assign pop = !fifo_empty &&
               ((state_q == S_IDLE) || tx_ready);

  send_fifo #(
    .DW (REQ_ENTRY_W),
    .AW (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef MPI_SEND_SEQ_EN
  logic [15:0] seq_q;
  logic [15:0] seq_d;

  assign seq_d   = pop ? seq_q + 16'd1 : seq_q;
  assign seq_cur = seq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) seq_q <= '0;
    else     seq_q <= seq_d;
  end
`else
  assign seq_cur = 16'h0000;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_valid_q <= 1'b0;
      tx_msg_q   <= '0;
      sent_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            tx_msg_q   <= build_pkt(head, seq_cur);
            tx_valid_q <= 1'b1;
            state_q    <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            sent_q <= sent_q + 32'd1;
            if (!fifo_empty) begin
              tx_msg_q <= build_pkt(head, seq_cur);
            end else begin
              tx_valid_q <= 1'b0;
              state_q    <= S_IDLE;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_message = tx_msg_q;
  assign sent_count = sent_q;
  assign Q_empty    = fifo_empty && (state_q == S_IDLE);

endmodule

// File: tb/tb_mpi_send_packetizer.sv
// Self-checking bench for mpi_send_packetizer: vector table plus
// scoreboard of expected packets, with fill/backpressure/reset sequences.
module tb_mpi_send_packetizer;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   my_rank;
  logic         req_valid;
  logic         req_ready;
  logic [7:0]   req_dst_rank;
  logic [7:0]   req_tag;
  logic [31:0]  req_payload;
  logic         tx_valid;
  logic         tx_ready;
  logic [127:0] tx_message;
  logic         Q_empty;
  logic [31:0]  sent_count;

  mpi_send_packetizer #(
    .packetizer_width (128),
    .RANK_BIT         (8),
    .TAG_BIT          (8),
    .FIFO_ADDR_WIDTH  (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .my_rank      (my_rank),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dst_rank (req_dst_rank),
    .req_tag      (req_tag),
    .req_payload  (req_payload),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_message   (tx_message),
    .Q_empty      (Q_empty),
    .sent_count   (sent_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  rank;
    logic [7:0]  dst;
    logic [7:0]  tag;
    logic [31:0] pl;
    logic [7:0]  e_dst;
    logic [15:0] e_pat;
    logic [31:0] e_pl;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q[$];
  int unsigned push_n   = 0;
  int unsigned sc_model = 0;

  function automatic logic [127:0] exp_pkt(
    input logic [7:0] dst, input logic [7:0] src,
    input logic [7:0] tag, input logic [31:0] pl,
    input int unsigned n
  );
    logic [15:0] m;
    logic [15:0] s;
`ifdef MPI_SEND_SEQ_EN
    m = 16'hFFFF;
`else
    m = 16'h0000;
`endif
    s = n[15:0] & m;
    return {8'h01, 8'h00, dst, src, tag, pl, s, 40'h0};
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Inputs only change at posedge+1, so negedge sees what the edge will see.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready) begin
        exp_q.push_back(exp_pkt(req_dst_rank, my_rank, req_tag,
                                req_payload, push_n));
        push_n++;
      end
      if (tx_valid && tx_ready) begin
        sc_model++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard: unexpected packet %h", tx_message);
        end else begin
          chk("scoreboard", tx_message, exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] rk, input logic [7:0] d,
                      input logic [7:0] t, input logic [31:0] p);
    int n;
    n = 0;
    my_rank      = rk;
    req_dst_rank = d;
    req_tag      = t;
    req_payload  = p;
    req_valid    = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: req_ready stayed 0");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || tx_valid) begin
      failures++;
      $display("FAIL drain_timeout: %0d pending", exp_q.size());
    end
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{8'h03, 8'h05, 8'h2A, 32'hDEADBEEF,
                8'h05, 16'h032A, 32'hDEADBEEF};
    vecs[1] = '{8'hFF, 8'h00, 8'h00, 32'h00000000,
                8'h00, 16'hFF00, 32'h00000000};
    vecs[2] = '{8'h00, 8'hFF, 8'hFF, 32'hFFFFFFFF,
                8'hFF, 16'h00FF, 32'hFFFFFFFF};
    vecs[3] = '{8'hA5, 8'h5A, 8'h3C, 32'h12345678,
                8'h5A, 16'hA53C, 32'h12345678};

    rst = 1'b1;
    req_valid = 1'b0;
    tx_ready = 1'b0;
    my_rank = '0;
    req_dst_rank = '0;
    req_tag = '0;
    req_payload = '0;
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_message", tx_message, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_q_empty", Q_empty, 1);
    chk("rst_sent_count", sent_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single sends: latency N+2 and field placement.
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      my_rank      = vecs[i].rank;
      req_dst_rank = vecs[i].dst;
      req_tag      = vecs[i].tag;
      req_payload  = vecs[i].pl;
      req_valid    = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("lat_n1_valid", tx_valid, 0);
      tick();
      chk("lat_n2_valid", tx_valid, 1);
      chk("f_type", tx_message[127:120], 8'h01);
      chk("f_rsvd", tx_message[119:112], 8'h00);
      chk("f_dst", tx_message[111:104], vecs[i].e_dst);
      chk("f_pattern", tx_message[103:88], vecs[i].e_pat);
      chk("f_payload", tx_message[87:56], vecs[i].e_pl);
      chk("f_low", tx_message[39:0], 0);
      tick();
      chk("v_sent_count", sent_count, i + 1);
      chk("v_q_empty", Q_empty, 1);
    end

    // Backpressure: packet held bit-stable, one acceptance.
    begin
      logic [127:0] held;
      tx_ready = 1'b0;
      push(8'h07, 8'h09, 8'h55, 32'hCAFEF00D);
      tick();
      chk("bp_valid", tx_valid, 1);
      held = tx_message;
      for (int k = 0; k < 10; k++) begin
        tick();
        chk("bp_hold", tx_message, held);
        chk("bp_valid_hold", tx_valid, 1);
      end
      tx_ready = 1'b1;
      tick();
      chk("bp_release_valid", tx_valid, 0);
      chk("bp_sent_count", sent_count, 5);
    end

    // Fill: 9 accepted with no drain, 10th refused.
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++)
      push(8'h11, 8'h20 + 8'(i), 8'(i), 32'hF0000000 + i);
    chk("fill_req_ready", req_ready, 0);
    chk("fill_q_empty", Q_empty, 0);
    my_rank      = 8'h11;
    req_dst_rank = 8'h29;
    req_tag      = 8'h09;
    req_payload  = 32'hF0000009;
    req_valid    = 1'b1;
    tick();
    chk("full_refused", req_ready, 0);
    // Pop while full: push still refused, then room for one.
    tx_ready = 1'b1;
    tick();
    chk("full_popped_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("b2b_sent_count", sent_count, 15);
    chk("b2b_done_valid", tx_valid, 0);
    drain();

`ifdef MPI_SEND_SEQ_EN
    // Sequence wrap: scoreboard stamps seq from push order.
    for (int i = 0; i < 65537; i++)
      push(8'h01, 8'h02, 8'h03, i);
    drain();
    chk("wrap_sent_count", sent_count, 15 + 65537);
`endif

    // Reset mid-transfer with 4 queued entries.
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(8'h33, 8'h44, 8'(i), 32'hBBBB0000 + i);
    chk("prerst_valid", tx_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_q_empty", Q_empty, 1);
    chk("mid_rst_sent", sent_count, 0);
    chk("mid_rst_ready", req_ready, 1);
    exp_q.delete();
    push_n   = 0;
    sc_model = 0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_q_empty", Q_empty, 1);
    tx_ready = 1'b1;
    push(8'h03, 8'h05, 8'h2A, 32'h0BADF00D);
    tick();
    chk("post_rst_seq", tx_message[55:40], 0);
    drain();
    chk("post_rst_sent", sent_count, 1);
    chk("sent_model", sent_count, sc_model);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
